// File: rtl/secure_boot_verifier_if.sv
// Boot-verifier signal bundle: power request, firmware ROM read channel and status.
// master = verifier side, slave = power logic / ROM / CPU gate side.
interface secure_boot_verifier_if #(
   parameter int unsigned DATA_W  = 8,
   parameter int unsigned ADDR_W  = 4,
   parameter int unsigned RETRY_W = 2
);
   logic               power_on;
   logic               fw_rd_en;
   logic [ADDR_W-1:0]  fw_addr;
   logic               fw_rd_valid;
   logic [DATA_W-1:0]  fw_rd_data;
   logic               busy;
   logic               boot_ok;
   logic               boot_fail;
   logic               auth_err;
   logic [RETRY_W-1:0] retry_cnt;

   modport master (
      input  power_on, fw_rd_valid, fw_rd_data,
      output fw_rd_en, fw_addr, busy, boot_ok, boot_fail, auth_err, retry_cnt
   );

   modport slave (
      output power_on, fw_rd_valid, fw_rd_data,
      input  fw_rd_en, fw_addr, busy, boot_ok, boot_fail, auth_err, retry_cnt
   );
endinterface

// File: rtl/secure_boot_verifier.sv
// Reads a firmware image word by word, folds it into a rotate-xor signature and
// compares it to a golden value; bounded retries, then a sticky tamper lockout.
module secure_boot_verifier #(
   parameter int unsigned       DATA_W      = 8,
   parameter int unsigned       NUM_WORDS   = 16,
   parameter int unsigned       MAX_RETRIES = 2,
   parameter logic [DATA_W-1:0] SEED        = {DATA_W{1'b0}},
   parameter logic [DATA_W-1:0] GOLDEN_SIG  = DATA_W'(8'hAA),
   localparam int unsigned      ADDR_W      = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1,
   localparam int unsigned      RETRY_W     = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   secure_boot_verifier_if.master  bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_WAIT,
      S_CHECK,
      S_PASS,
      S_LOCKED
   } state_t;

   localparam logic [ADDR_W-1:0]  LAST_IDX  = ADDR_W'(NUM_WORDS - 1);
   localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);

   state_t             state_q, state_d;
   logic [ADDR_W-1:0]  idx_q, idx_d;
   logic [DATA_W-1:0]  sig_q, sig_d;
   logic [RETRY_W-1:0] retry_q, retry_d;
   logic               auth_err_q, auth_err_d;

   logic [DATA_W-1:0]  sig_fold;

   // One signature step: rotate left by one bit, then absorb the incoming word.
   assign sig_fold = {sig_q[DATA_W-2:0], sig_q[DATA_W-1]} ^ bus.fw_rd_data;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         idx_q      <= '0;
         sig_q      <= SEED;
         retry_q    <= '0;
         auth_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         sig_q      <= sig_d;
         retry_q    <= retry_d;
         auth_err_q <= auth_err_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      sig_d      = sig_q;
      retry_d    = retry_q;
      auth_err_d = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            idx_d = '0;
            sig_d = SEED;
            if (bus.power_on) begin
               state_d = S_FETCH;
            end
         end

         S_FETCH: begin
            state_d = S_WAIT;
         end

         S_WAIT: begin
            if (bus.fw_rd_valid) begin
               sig_d = sig_fold;
               if (idx_q == LAST_IDX) begin
                  state_d = S_CHECK;
               end else begin
                  idx_d   = idx_q + ADDR_W'(1);
                  state_d = S_FETCH;
               end
            end
         end

         S_CHECK: begin
            if (sig_q == GOLDEN_SIG) begin
               state_d = S_PASS;
            end else begin
               auth_err_d = 1'b1;
               if (retry_q < RETRY_MAX) begin
                  retry_d = retry_q + RETRY_W'(1);
                  idx_d   = '0;
                  sig_d   = SEED;
                  state_d = S_FETCH;
               end else begin
                  state_d = S_LOCKED;
               end
            end
         end

         S_PASS: begin
            state_d = S_PASS;
         end

         S_LOCKED: begin
            state_d = S_LOCKED;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Dropping the power request abandons any attempt in flight without
      // counting it as a failure; the retry budget is deliberately kept.
      if (!bus.power_on && (state_q == S_FETCH || state_q == S_WAIT ||
                            state_q == S_CHECK || state_q == S_PASS)) begin
         state_d    = S_IDLE;
         idx_d      = '0;
         sig_d      = SEED;
         retry_d    = retry_q;
         auth_err_d = 1'b0;
      end
   end

   assign bus.fw_rd_en  = (state_q == S_FETCH);
   assign bus.fw_addr   = idx_q;
   assign bus.busy      = (state_q == S_FETCH) || (state_q == S_WAIT) || (state_q == S_CHECK);
   assign bus.boot_ok   = (state_q == S_PASS);
   assign bus.boot_fail = (state_q == S_LOCKED);
   assign bus.auth_err  = auth_err_q;
   assign bus.retry_cnt = retry_q;

endmodule

// File: tb/tb_secure_boot_verifier.sv
// Bench for secure_boot_verifier: vector table, hand-written corner sequences and
// randomized images checked against a transaction-level signature/latency model.
module tb_secure_boot_verifier;

   localparam int N  = 4;
   localparam int DW = 8;
   localparam int AW = 2;
   localparam int RW = 2;
   localparam logic [7:0] GOLD = 8'h33;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   secure_boot_verifier_if #(.DATA_W(DW), .ADDR_W(AW), .RETRY_W(RW)) bus ();

   secure_boot_verifier #(
      .DATA_W(DW), .NUM_WORDS(N), .MAX_RETRIES(2), .SEED(8'h00), .GOLDEN_SIG(GOLD)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int vectors = 0;
   int miscompares = 0;

   logic [7:0] rom [N];
   int  ws = 0;
   bit  junk_en = 1'b0;
   int  rsp_cnt = 0;
   int  rsp_addr = 0;
   int  exp_next = 0;
   int  last_addr = 0;

   typedef struct {
      string       name;
      logic [31:0] img;
      int          wst;
      bit          exp_ok;
      bit          exp_fail;
      int          exp_edges;
      int          exp_auths;
      int          exp_retry;
   } vec_t;

   vec_t tbl [5];

   task automatic chk(input string name, input int act, input int exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // ROM model: answers ws wait cycles after the read strobe; optional junk valids
   // are only ever driven while no read is outstanding.
   initial begin
      bus.fw_rd_valid = 1'b0;
      bus.fw_rd_data  = '0;
      forever begin
         step();
         bus.fw_rd_valid = 1'b0;
         bus.fw_rd_data  = '0;
         if (bus.fw_rd_en) begin
            rsp_cnt  = ws + 1;
            rsp_addr = int'(bus.fw_addr);
         end else if (rsp_cnt > 0) begin
            rsp_cnt--;
            if (rsp_cnt == 0) begin
               bus.fw_rd_valid = 1'b1;
               bus.fw_rd_data  = rom[rsp_addr];
            end
         end else if (junk_en && $urandom_range(3) == 0) begin
            bus.fw_rd_valid = 1'b1;
            bus.fw_rd_data  = 8'($urandom);
         end
      end
   end

   // Read-order monitor: strobes walk 0..N-1 and the address holds while busy.
   initial begin
      forever begin
         step();
         if (rst_n === 1'b1) begin
            if (bus.fw_rd_en) begin
               chk("rd_addr_order", int'(bus.fw_addr), exp_next);
               last_addr = int'(bus.fw_addr);
               exp_next  = (int'(bus.fw_addr) + 1) % N;
            end else if (bus.busy) begin
               chk("rd_addr_hold", int'(bus.fw_addr), last_addr);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1);
   end

   task automatic chk_reset(input string tag);
      chk({tag, ".fw_rd_en"},  int'(bus.fw_rd_en),  0);
      chk({tag, ".fw_addr"},   int'(bus.fw_addr),   0);
      chk({tag, ".busy"},      int'(bus.busy),      0);
      chk({tag, ".boot_ok"},   int'(bus.boot_ok),   0);
      chk({tag, ".boot_fail"}, int'(bus.boot_fail), 0);
      chk({tag, ".auth_err"},  int'(bus.auth_err),  0);
      chk({tag, ".retry_cnt"}, int'(bus.retry_cnt), 0);
   endtask

   task automatic do_reset();
      step();
      bus.power_on = 1'b0;
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      exp_next  = 0;
      last_addr = 0;
   endtask

   task automatic load_img(input logic [31:0] img);
      for (int i = 0; i < N; i++) rom[i] = img[8*(N-1-i) +: 8];
   endtask

   // Raises power_on and counts edges until the verdict; the edge that samples
   // power_on in IDLE is edge 1.
   task automatic run_boot(input string tag, output int edges, output int auths);
      edges = 0;
      auths = 0;
      bus.power_on = 1'b1;
      while (edges < 3000) begin
         step();
         edges++;
         if (bus.auth_err) auths++;
         if (bus.boot_ok || bus.boot_fail) break;
      end
      if (edges >= 3000) begin
         vectors++;
         miscompares++;
         $display("FAIL %s.timeout: got no verdict in %0d edges, required boot_ok or boot_fail", tag, edges);
      end
   endtask

   task automatic wait_fetch(input int a, input string tag);
      int k;
      for (k = 0; k < 200; k++) begin
         step();
         if (bus.fw_rd_en && int'(bus.fw_addr) == a) break;
      end
      if (k == 200) begin
         vectors++;
         miscompares++;
         $display("FAIL %s.wait_fetch: got no strobe, required fetch of addr %0d within 200 cycles", tag, a);
      end
   endtask

   function automatic int model_sig();
      int s = 0;
      for (int i = 0; i < N; i++) s = (((s * 2) % 256) + (s / 128)) ^ int'(rom[i]);
      return s;
   endfunction

   initial begin
      int edges, auths, sig, w, e_edges, e_auths, e_retry;
      bit e_ok;
      string tag;

      bus.power_on = 1'b0;
      load_img(32'hA53C0FF0);

      tbl[0] = '{"good_ws0",     32'hA53C0FF0, 0, 1'b1, 1'b0, 10, 0, 0};
      tbl[1] = '{"good_ws3",     32'hA53C0FF0, 3, 1'b1, 1'b0, 22, 0, 0};
      tbl[2] = '{"good_ws1",     32'hA53C0FF0, 1, 1'b1, 1'b0, 14, 0, 0};
      tbl[3] = '{"tampered_ws0", 32'hA53C0FF1, 0, 1'b0, 1'b1, 28, 3, 2};
      tbl[4] = '{"tampered_ws1", 32'hA53C0FF1, 1, 1'b0, 1'b1, 40, 3, 2};

      step();
      step();
      chk_reset("por");
      rst_n = 1'b1;

      foreach (tbl[v]) begin
         do_reset();
         load_img(tbl[v].img);
         ws = tbl[v].wst;
         run_boot(tbl[v].name, edges, auths);
         $display("vector %s: edges=%0d auths=%0d ok=%0b fail=%0b retry=%0d",
                  tbl[v].name, edges, auths, bus.boot_ok, bus.boot_fail, bus.retry_cnt);
         chk({tbl[v].name, ".edges"},     edges,                   tbl[v].exp_edges);
         chk({tbl[v].name, ".auths"},     auths,                   tbl[v].exp_auths);
         chk({tbl[v].name, ".boot_ok"},   int'(bus.boot_ok),       int'(tbl[v].exp_ok));
         chk({tbl[v].name, ".boot_fail"}, int'(bus.boot_fail),     int'(tbl[v].exp_fail));
         chk({tbl[v].name, ".retry_cnt"}, int'(bus.retry_cnt),     tbl[v].exp_retry);
      end

      // Lockout is absorbing: power toggling has no effect.
      do_reset();
      load_img(32'hA53C0FF1);
      ws = 0;
      run_boot("locked", edges, auths);
      for (int k = 0; k < 8; k++) begin
         bus.power_on = k[0];
         step();
         chk("locked.boot_fail", int'(bus.boot_fail), 1);
         chk("locked.boot_ok",   int'(bus.boot_ok),   0);
         chk("locked.busy",      int'(bus.busy),      0);
         chk("locked.fw_rd_en",  int'(bus.fw_rd_en),  0);
         chk("locked.retry_cnt", int'(bus.retry_cnt), 2);
      end
      $display("sequence locked: power toggled 8 cycles");

      // Transient fault: first pass tampered, ROM repaired before the retry.
      do_reset();
      load_img(32'hA53C0FF1);
      ws = 0;
      bus.power_on = 1'b1;
      edges = 0;
      auths = 0;
      while (edges < 500) begin
         step();
         edges++;
         if (bus.auth_err) begin
            auths++;
            rom[3] = 8'hF0;
            chk("transient.retry_at_pulse", int'(bus.retry_cnt), 1);
            chk("transient.refetch_same_cycle", int'(bus.fw_rd_en), 1);
         end
         if (bus.boot_ok || bus.boot_fail) break;
      end
      chk("transient.edges",     edges,               19);
      chk("transient.auths",     auths,               1);
      chk("transient.retry_cnt", int'(bus.retry_cnt), 1);
      chk("transient.boot_ok",   int'(bus.boot_ok),   1);
      $display("sequence transient: edges=%0d auths=%0d", edges, auths);

      // Power drop while word 2 is being returned: data discarded, restart from 0.
      do_reset();
      load_img(32'hA53C0FF0);
      ws = 0;
      bus.power_on = 1'b1;
      wait_fetch(2, "drop_wait");
      step();
      chk("drop_wait.busy_in_wait", int'(bus.busy), 1);
      bus.power_on = 1'b0;
      exp_next = 0;
      step();
      chk("drop_wait.busy",    int'(bus.busy),    0);
      chk("drop_wait.boot_ok", int'(bus.boot_ok), 0);
      chk("drop_wait.fw_addr", int'(bus.fw_addr), 0);
      run_boot("drop_wait.rerun", edges, auths);
      chk("drop_wait.rerun_edges", edges,             10);
      chk("drop_wait.rerun_ok",    int'(bus.boot_ok), 1);
      bus.power_on = 1'b0;
      step();
      chk("drop_pass.boot_ok", int'(bus.boot_ok), 0);
      $display("sequence drop_wait: rerun edges=%0d", edges);

      // Power drop in CHECK with a mismatch: no pulse, no retry consumed.
      do_reset();
      load_img(32'hA53C0FF1);
      bus.power_on = 1'b1;
      wait_fetch(3, "drop_check");
      step();
      step();
      chk("drop_check.busy_in_check", int'(bus.busy), 1);
      bus.power_on = 1'b0;
      exp_next = 0;
      step();
      chk("drop_check.auth_err",  int'(bus.auth_err),  0);
      chk("drop_check.retry_cnt", int'(bus.retry_cnt), 0);
      chk("drop_check.busy",      int'(bus.busy),      0);
      $display("sequence drop_check: retry_cnt=%0d", bus.retry_cnt);

      // Asynchronous reset mid-read after one failure: everything back to reset values.
      do_reset();
      load_img(32'hA53C0FF1);
      bus.power_on = 1'b1;
      for (int k = 0; k < 100 && !bus.auth_err; k++) step();
      chk("midrst.retry_before", int'(bus.retry_cnt), 1);
      step();
      step();
      #2;
      rst_n = 1'b0;
      #1;
      chk_reset("midrst");
      do_reset();
      $display("sequence midrst: reset asserted during read");

      // Randomized images and wait states against the signature/latency model.
      junk_en = 1'b1;
      for (int t = 0; t < 24; t++) begin
         do_reset();
         ws = $urandom_range(0, 3);
         for (int i = 0; i < N; i++) rom[i] = 8'($urandom);
         if ($urandom_range(1) == 1) begin
            rom[N-1] = 8'h00;
            sig = model_sig();
            rom[N-1] = 8'(sig ^ int'(GOLD));
         end
         sig  = model_sig();
         e_ok = (sig == int'(GOLD));
         w    = N * (2 + ws);
         e_edges = e_ok ? (2 + w) : (1 + 3 * (w + 1));
         e_auths = e_ok ? 0 : 3;
         e_retry = e_ok ? 0 : 2;
         tag = $sformatf("rand%0d", t);
         run_boot(tag, edges, auths);
         $display("trial %0d: ws=%0d sig=%02h ok=%0b edges=%0d auths=%0d", t, ws, sig, e_ok, edges, auths);
         chk({tag, ".edges"},     edges,                e_edges);
         chk({tag, ".auths"},     auths,                e_auths);
         chk({tag, ".boot_ok"},   int'(bus.boot_ok),    int'(e_ok));
         chk({tag, ".boot_fail"}, int'(bus.boot_fail),  int'(!e_ok));
         chk({tag, ".retry_cnt"}, int'(bus.retry_cnt),  e_retry);
      end
      junk_en = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
